// File: rtl/posit8_mul_core.sv
// Two-stage posit8 (es=1) multiplier core: S1 forms sign, scale sum and raw
// mantissa product; S2 normalizes and its registers drive the outputs.
module posit8_mul_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       a_sign,
    input  logic       b_sign,
    input  logic [3:0] a_regi,
    input  logic [3:0] b_regi,
    input  logic       a_expo,
    input  logic       b_expo,
    input  logic [3:0] a_frac,
    input  logic [3:0] b_frac,
    input  logic       a_zero,
    input  logic       b_zero,
    input  logic       a_inf,
    input  logic       b_inf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sign,
    output logic [5:0] out_scale,
    output logic [7:0] out_frac,
    output logic       out_sticky,
    output logic       out_zero,
    output logic       out_nar
);

    // Handshake: a transfer happens when valid and ready are both high at a
    // rising edge; valid never waits on ready, and ready never looks at valid.
    logic       s1_valid;
    logic       s1_sign;
    logic [5:0] s1_scale;
    logic [9:0] s1_prod;
    logic       s1_nar;
    logic       s1_zero;

    logic       s1_adv;
    logic       s2_adv;

    logic [5:0] a_scale;
    logic [5:0] b_scale;
    logic [9:0] prod;
    logic       in_nar;

    logic       n_sign;
    logic [5:0] n_scale;
    logic [7:0] n_frac;
    logic       n_sticky;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // 2*regi + expo is the sign-extended regime with expo as its new LSB.
    assign a_scale = {a_regi[3], a_regi, a_expo};
    assign b_scale = {b_regi[3], b_regi, b_expo};
    assign prod    = 10'({1'b1, a_frac}) * 10'({1'b1, b_frac});
    assign in_nar  = a_inf || b_inf;

    always_comb begin
        n_sign   = s1_sign;
        n_scale  = s1_scale;
        n_frac   = s1_prod[7:0];
        n_sticky = 1'b0;
        if (s1_prod[9]) begin
            n_scale  = s1_scale + 6'd1;
            n_frac   = s1_prod[8:1];
            n_sticky = s1_prod[0];
        end
        if (s1_nar || s1_zero) begin
            n_sign   = 1'b0;
            n_scale  = 6'd0;
            n_frac   = 8'd0;
            n_sticky = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_scale   <= 6'd0;
            s1_prod    <= 10'd0;
            s1_nar     <= 1'b0;
            s1_zero    <= 1'b0;
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_scale  <= 6'd0;
            out_frac   <= 8'd0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
            out_nar    <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign  <= a_sign ^ b_sign;
                    s1_scale <= a_scale + b_scale;
                    s1_prod  <= prod;
                    s1_nar   <= in_nar;
                    s1_zero  <= (a_zero || b_zero) && !in_nar;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_sign   <= n_sign;
                    out_scale  <= n_scale;
                    out_frac   <= n_frac;
                    out_sticky <= n_sticky;
                    out_zero   <= s1_zero;
                    out_nar    <= s1_nar;
                end
            end
        end
    end

endmodule

// File: doc/posit8_mul_core.md
POSIT8_MUL_CORE -- requirements
Module: posit8_mul_core

Interface
REQ-001 SHALL expose ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  core accepts pair this cycle.
- a_sign, b_sign  in  1  operand sign.
- a_regi, b_regi  in  4  regime k, two's complement, range -6..+6.
- a_expo, b_expo  in  1  exponent bit (es=1).
- a_frac, b_frac  in  4  fraction bits after hidden 1.
- a_zero, b_zero  in  1  operand is zero.
- a_inf, b_inf  in  1  operand is NaR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  product sign.
- out_scale  out  6  product scale, two's complement.
- out_frac  out  8  normalized fraction after hidden 1.
- out_sticky  out  1  OR of bits dropped by normalization.
- out_zero  out  1  product is zero.
- out_nar  out  1  product is NaR.

Function
REQ-002 Operand value SHALL be (-1)^sign x 2^(2*regi+expo) x 1.frac; the operand fields arrive already decoded, one pair per accepted transfer.
REQ-003 A transfer SHALL occur on any cycle with in_valid=1 and in_ready=1; an output handoff SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-004 The core SHALL be a two-stage pipeline, S1 then S2; the S2 registers drive the outputs directly.
REQ-005 S1 SHALL register the following:
- sign = a_sign XOR b_sign;
- scale_sum = (2*a_regi + a_expo) + (2*b_regi + b_expo), 6-bit signed;
- 10-bit unsigned product p = {1,a_frac} x {1,b_frac};
- nar = a_inf OR b_inf;
- zero = (a_zero OR b_zero) AND NOT nar.
REQ-006 S2 normalization when p[9]=1: out_scale = scale_sum+1, out_frac = p[8:1], out_sticky = p[0].
REQ-007 S2 normalization when p[9]=0: out_scale = scale_sum, out_frac = p[7:0], out_sticky = 0.
REQ-008 When nar or zero is set, S2 SHALL force out_sign, out_scale, out_frac and out_sticky to 0.
REQ-009 NaR SHALL dominate zero: NaR x 0 gives out_nar=1 and out_zero=0.
REQ-010 Flow control SHALL be:
- s2_adv = !s2_valid OR out_ready;
- s1_adv = !s1_valid OR s2_adv;
- in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-011 With no stall, latency SHALL be exactly 2 cycles from transfer to out_valid, and throughput SHALL be one result per cycle.
REQ-012 While out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-013 A stalled stage SHALL hold its contents; no result may be dropped or duplicated, and results SHALL leave in acceptance order.
REQ-014 A simultaneous output handoff and input transfer on a full pipeline SHALL move every stage forward by one in the same cycle.
REQ-015 The scale range SHALL stay within -24..+27; no saturation or overflow logic is required at this stage.

Reset
REQ-016 While rst=1 at a clock edge:
- s1_valid and s2_valid clear to 0;
- out_valid = 0;
- all output data fields = 0.
REQ-017 Reset SHALL discard any in-flight results.
REQ-018 During rst=1, in_ready SHALL still follow REQ-010, but no transfer SHALL be recorded.
REQ-019 The first transfer after reset SHALL be possible on the first cycle with rst=0.

Verification
REQ-020 Case 1.0 x 1.0:
- stimulus: both regi=0, expo=0, frac=0000, in_valid=1, out_ready=1;
- response: after 2 cycles, out_valid=1, out_scale=0, out_frac=8'h00, out_sticky=0.
REQ-021 Case 1.5 x 1.5:
- stimulus: both frac=1000, regi=0, expo=0;
- response: out_scale=1, out_frac=8'h20, out_sticky=0.
REQ-022 Case maxpos x maxpos:
- stimulus: both regi=6, expo=1, frac=1111;
- response: out_scale=27, out_frac=8'hE0, out_sticky=1.
REQ-023 Case NaR x 0 and sign handling:
- a_inf=1 with b_zero=1 -> out_nar=1, out_zero=0, other fields 0;
- a_zero=1 with b operand 1.0 -> out_zero=1;
- a_sign=1, b_sign=1, both 1.0 -> out_sign=0.
REQ-024 Case backpressure:
- stimulus: hold out_ready=0 and offer 3 pairs back-to-back;
- response: first two accepted, in_ready=0 on the third cycle, outputs stable;
- then raise out_ready: the three results drain in order on consecutive cycles.
REQ-025 Case reset mid-operation:
- stimulus: assert rst for 1 cycle with both stages valid;
- response: out_valid=0 on the next cycle, no stale result emitted;
- a new pair accepted right after reset appears 2 cycles later.
